// File: rtl/regfile_pkg.sv
// Shared constants for the RV32I integer register file.
package regfile_pkg;

  localparam int unsigned REGFILE_DATA_WIDTH = 32;
  localparam int unsigned REGFILE_ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS           = 2**REGFILE_ADDR_WIDTH;
  localparam int unsigned ZERO_REG           = 0;

  function automatic int unsigned num_regs_for(input int unsigned addr_width);
    return 2**addr_width;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// Combinational read port: array mux with x0 forced to zero and an optional
// write-through bypass compare (bypass enable supplied by the parent).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REGFILE_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = REGFILE_ADDR_WIDTH
) (
  input  logic [(2**ADDR_WIDTH)-1:1][DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]                      addr,
  input  logic                                       byp_en,
  input  logic [ADDR_WIDTH-1:0]                      byp_addr,
  input  logic [DATA_WIDTH-1:0]                      byp_data,
  output logic [DATA_WIDTH-1:0]                      rdata
);

  localparam int unsigned NREGS = num_regs_for(ADDR_WIDTH);

  always_comb begin
    rdata = '0;
    if (addr != ADDR_WIDTH'(ZERO_REG)) begin
      if (byp_en && (addr == byp_addr)) begin
        rdata = byp_data;
      end else begin
        for (int unsigned i = 1; i < NREGS; i++) begin
          if (addr == ADDR_WIDTH'(i)) rdata = regs[i];
        end
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: x0 hardwired to zero, two operand read ports,
// one debug read port, one synchronous write port.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through forwarding.
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REGFILE_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = REGFILE_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we3,
  input  logic [ADDR_WIDTH-1:0] wa3,
  input  logic [DATA_WIDTH-1:0] wd3,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int unsigned NREGS = num_regs_for(ADDR_WIDTH);

  // Storage starts at x1; x0 has no flops.
  logic [NREGS-1:1][DATA_WIDTH-1:0] regs;
  logic                             byp_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        if (we3 && (wa3 == ADDR_WIDTH'(i))) regs[i] <= wd3;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign byp_en = we3 && (wa3 != ADDR_WIDTH'(ZERO_REG)) && !reset;
`else
  assign byp_en = 1'b0;
`endif

  regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rp1 (
    .regs     (regs),
    .addr     (ra1),
    .byp_en   (byp_en),
    .byp_addr (wa3),
    .byp_data (wd3),
    .rdata    (rd1)
  );

  regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rp2 (
    .regs     (regs),
    .addr     (ra2),
    .byp_en   (byp_en),
    .byp_addr (wa3),
    .byp_data (wd3),
    .rdata    (rd2)
  );

  regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rp_dbg (
    .regs     (regs),
    .addr     (dbg_addr),
    .byp_en   (byp_en),
    .byp_addr (wa3),
    .byp_data (wd3),
    .rdata    (dbg_data)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed plan plus randomized
// traffic against an array reference model (REGFILE_BYPASS_EN aware).
module tb_register_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned N  = 2**AW;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          we3 = 1'b0;
  logic [AW-1:0] wa3 = '0;
  logic [DW-1:0] wd3 = '0;
  logic [AW-1:0] ra1 = '0;
  logic [AW-1:0] ra2 = '0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] rd1, rd2, dbg_data;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [DW-1:0] model [N];

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected read value for the inputs currently driven.
  function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYPASS && we3 && !reset && wa3 == a) return wd3;
    return model[a];
  endfunction

  task automatic check_ports(input string tag);
    check({tag, ".rd1"}, rd1, expect_rd(ra1));
    check({tag, ".rd2"}, rd2, expect_rd(ra2));
    check({tag, ".dbg"}, dbg_data, expect_rd(dbg_addr));
  endtask

  // One clock: drive, check before the edge, clock, update model, check after.
  task automatic cycle(input logic r, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [AW-1:0] ad,
                       input string tag);
    @(negedge clk);
    reset = r; we3 = we; wa3 = wa; wd3 = wd; ra1 = a1; ra2 = a2; dbg_addr = ad;
    #1;
    check_ports({tag, ".pre"});
    @(posedge clk);
    if (r) begin
      for (int unsigned i = 0; i < N; i++) model[i] = '0;
    end else if (we && wa != 0) begin
      model[wa] = wd;
    end
    #1;
    check_ports({tag, ".post"});
  endtask

  initial begin
    for (int unsigned i = 0; i < N; i++) model[i] = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, "rst_x0");
    for (int unsigned i = 0; i < N; i++)
      cycle(1'b0, 1'b0, 5'd0, 32'h0, AW'(i), AW'(N - 1 - i), AW'(i), "rst_all");

    cycle(1'b0, 1'b1, 5'd1, 32'hA5A5A5A5, 5'd0, 5'd0, 5'd0, "wr_x1");
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 5'd1, "rd_x1");

    cycle(1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0, "wr_x0");
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, "rd_x0");

    cycle(1'b0, 1'b1, 5'd1, 32'h11112222, 5'd0, 5'd0, 5'd0, "ovw_x1");
    cycle(1'b0, 1'b1, 5'd2, 32'hCAFEBABE, 5'd0, 5'd0, 5'd0, "wr_x2");
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd1, 5'd0, "rd_x2_x1");

    cycle(1'b0, 1'b1, 5'd3, 32'hFEEDF00D, 5'd0, 5'd0, 5'd0, "wr_x3");
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd3, "dbg_x3");
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, "dbg_x0");

    cycle(1'b0, 1'b1, 5'd4, 32'h0BADC0DE, 5'd0, 5'd0, 5'd0, "wr_x4");
    cycle(1'b1, 1'b1, 5'd4, 32'h12345678, 5'd4, 5'd4, 5'd4, "rst_vs_wr");
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd3, "rst_rd_a");
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 5'd4, "rst_rd_b");
    check("x4_after_rst", dbg_data, 32'h0);

    cycle(1'b0, 1'b1, 5'd5, 32'h01234567, 5'd0, 5'd0, 5'd0, "wr_x5_old");
    cycle(1'b0, 1'b1, 5'd5, 32'h89ABCDEF, 5'd5, 5'd5, 5'd5, "rw_same");
    check("rw_same_new", rd1, 32'h89ABCDEF);
    cycle(1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 5'd31, "wr_x31");

    for (int unsigned k = 0; k < 400; k++) begin
      logic          r, we;
      logic [AW-1:0] wa, a1, a2, ad;
      logic [DW-1:0] wd;
      r  = ($urandom_range(0, 39) == 0);
      we = $urandom_range(0, 1) == 1;
      wa = AW'($urandom_range(0, N - 1));
      wd = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, N - 1));
      a2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, N - 1));
      ad = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, N - 1));
      cycle(r, we, wa, wd, a1, a2, ad, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
